// File: rtl/game_session_if.sv
// Signal bundle between the session sequencer (master) and the keypad decoder,
// credit keeper and game core (slave).
// Handshakes: key_valid, deduct_ack and game_done are single-cycle pulses;
// deduct_req is held high until the deduct_ack pulse or a timeout, and
// deduct_amt is only meaningful while deduct_req is high.
interface game_session_if;
   logic       key_valid;
   logic [8:0] key_code;
   logic [6:0] money;
   logic       deduct_req;
   logic [6:0] deduct_amt;
   logic       deduct_ack;
   logic       game_start;
   logic [2:0] level;
   logic       ticket;
   logic       game_done;
   logic       no_money;
   logic [1:0] screen_sel;
   logic [2:0] state_dbg;

   modport master (
      input  key_valid, key_code, money, deduct_ack, game_done,
      output deduct_req, deduct_amt, game_start, level, ticket, no_money,
             screen_sel, state_dbg
   );

   modport slave (
      output key_valid, key_code, money, deduct_ack, game_done,
      input  deduct_req, deduct_amt, game_start, level, ticket, no_money,
             screen_sel, state_dbg
   );
endinterface

// File: rtl/game_session_ctrl.sv
// Arcade session sequencer: menu keys -> fee charge -> game -> result screen.
// Define GS_HELP_EN to build the help screen reached with the '?' key.
module game_session_ctrl #(
   parameter int FEE           = 10,
   parameter int ACK_TIMEOUT   = 1023,
   parameter int RESULT_CYCLES = 100_000_000
) (
   input logic            clk,
   input logic            rst_n,
   game_session_if.master bus
);
   localparam int WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam int DW = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

   localparam logic [8:0] KEY_1     = 9'h016;
   localparam logic [8:0] KEY_2     = 9'h01E;
   localparam logic [8:0] KEY_3     = 9'h026;
   localparam logic [8:0] KEY_SPACE = 9'h029;
`ifdef GS_HELP_EN
   localparam logic [8:0] KEY_HELP  = 9'h04A;
`endif

   typedef enum logic [2:0] {
      S_MENU   = 3'd0,
      S_CHARGE = 3'd1,
      S_PLAY   = 3'd2,
`ifdef GS_HELP_EN
      S_HELP   = 3'd4,
`endif
      S_RESULT = 3'd3
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [WW-1:0] r_wait, w_wait_nxt;
   logic [DW-1:0] r_dwell, w_dwell_nxt;
   logic [1:0]    r_pend, w_pend_nxt;
   logic [2:0]    r_level, w_level_nxt;
   logic          r_ticket, w_ticket_nxt;
   logic          r_start, w_start_nxt;
   logic          r_no_money, w_no_money_nxt;
   logic          r_req, w_req_nxt;
   logic [6:0]    r_amt;
   logic [1:0]    r_screen, w_screen_nxt;
   logic [1:0]    w_key_num;
   logic          w_key_lvl;
   logic          w_key_space;

   always_comb begin
      w_key_num = 2'd0;
      case (bus.key_code)
         KEY_1:   w_key_num = 2'd1;
         KEY_2:   w_key_num = 2'd2;
         KEY_3:   w_key_num = 2'd3;
         default: w_key_num = 2'd0;
      endcase
      w_key_lvl   = bus.key_valid && (w_key_num != 2'd0);
      w_key_space = bus.key_valid && (bus.key_code == KEY_SPACE);
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_nxt     = r_wait;
      w_dwell_nxt    = r_dwell;
      w_pend_nxt     = r_pend;
      w_level_nxt    = r_level;
      w_ticket_nxt   = r_ticket;
      w_start_nxt    = 1'b0;
      w_no_money_nxt = 1'b0;
      case (r_state)
         S_MENU: begin
            // money is only looked at in the cycle the level key arrives
            if (w_key_lvl) begin
               if (bus.money >= 7'(FEE)) begin
                  w_pend_nxt  = w_key_num;
                  w_wait_nxt  = '0;
                  w_state_nxt = S_CHARGE;
               end else begin
                  w_no_money_nxt = 1'b1;
               end
            end
`ifdef GS_HELP_EN
            else if (bus.key_valid && bus.key_code == KEY_HELP) begin
               w_level_nxt = 3'd4;
               w_state_nxt = S_HELP;
            end
`endif
         end
         S_CHARGE: begin
            // ack is tested first so it wins over a coincident timeout
            if (bus.deduct_ack) begin
               w_level_nxt  = {1'b0, r_pend};
               w_ticket_nxt = 1'b1;
               w_start_nxt  = 1'b1;
               w_state_nxt  = S_PLAY;
            end else if (r_wait == WW'(ACK_TIMEOUT - 1)) begin
               w_no_money_nxt = 1'b1;
               w_level_nxt    = 3'd0;
               w_state_nxt    = S_MENU;
            end else begin
               w_wait_nxt = r_wait + 1'b1;
            end
         end
         S_PLAY: begin
            if (bus.game_done) begin
               w_dwell_nxt = DW'(RESULT_CYCLES - 1);
               w_state_nxt = S_RESULT;
            end
         end
         S_RESULT: begin
            if (r_dwell == '0 || w_key_space) begin
               w_level_nxt  = 3'd0;
               w_ticket_nxt = 1'b0;
               w_state_nxt  = S_MENU;
            end else begin
               w_dwell_nxt = r_dwell - 1'b1;
            end
         end
`ifdef GS_HELP_EN
         S_HELP: begin
            if (w_key_space || (bus.key_valid && bus.key_code == KEY_HELP)) begin
               w_level_nxt = 3'd0;
               w_state_nxt = S_MENU;
            end
         end
`endif
         default: begin
            w_level_nxt  = 3'd0;
            w_ticket_nxt = 1'b0;
            w_state_nxt  = S_MENU;
         end
      endcase

      w_req_nxt = (w_state_nxt == S_CHARGE);
      case (w_state_nxt)
         S_PLAY:   w_screen_nxt = 2'd1;
         S_RESULT: w_screen_nxt = 2'd3;
`ifdef GS_HELP_EN
         S_HELP:   w_screen_nxt = 2'd2;
`endif
         default:  w_screen_nxt = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_MENU;
         r_wait     <= '0;
         r_dwell    <= '0;
         r_pend     <= 2'd0;
         r_level    <= 3'd0;
         r_ticket   <= 1'b0;
         r_start    <= 1'b0;
         r_no_money <= 1'b0;
         r_req      <= 1'b0;
         r_amt      <= 7'd0;
         r_screen   <= 2'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait     <= w_wait_nxt;
         r_dwell    <= w_dwell_nxt;
         r_pend     <= w_pend_nxt;
         r_level    <= w_level_nxt;
         r_ticket   <= w_ticket_nxt;
         r_start    <= w_start_nxt;
         r_no_money <= w_no_money_nxt;
         r_req      <= w_req_nxt;
         r_amt      <= w_req_nxt ? 7'(FEE) : 7'd0;
         r_screen   <= w_screen_nxt;
      end
   end

   assign bus.deduct_req = r_req;
   assign bus.deduct_amt = r_amt;
   assign bus.game_start = r_start;
   assign bus.level      = r_level;
   assign bus.ticket     = r_ticket;
   assign bus.no_money   = r_no_money;
   assign bus.screen_sel = r_screen;
   assign bus.state_dbg  = r_state;
endmodule

// File: tb/tb_game_session_ctrl.sv
// Bench for game_session_ctrl: fixed-cycle stimulus, pulse-event scoreboard,
// and direct output checks at posedge+1.
module tb_game_session_ctrl;
   localparam int FEE     = 10;
   localparam int ACK_TO  = 16;
   localparam int RES_CYC = 8;
   localparam int W       = 9;

   localparam logic [8:0] KEY_1     = 9'h016;
   localparam logic [8:0] KEY_2     = 9'h01E;
   localparam logic [8:0] KEY_3     = 9'h026;
   localparam logic [8:0] KEY_HELP  = 9'h04A;
   localparam logic [8:0] KEY_SPACE = 9'h029;

   localparam logic [2:0] ST_MENU   = 3'd0;
   localparam logic [2:0] ST_CHARGE = 3'd1;
   localparam logic [2:0] ST_PLAY   = 3'd2;
   localparam logic [2:0] ST_HELP   = 3'd4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   game_session_if bus();

   game_session_ctrl #(
      .FEE           (FEE),
      .ACK_TIMEOUT   (ACK_TO),
      .RESULT_CYCLES (RES_CYC)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // event word: {game_start, no_money, level, ticket, screen_sel, deduct_req}
   function automatic logic [W-1:0] evt(input logic gs, input logic nm, input logic [2:0] lvl,
                                        input logic tk, input logic [1:0] scr, input logic req);
      return {gs, nm, lvl, tk, scr, req};
   endfunction

   always @(negedge clk) begin : mon
      logic [W-1:0] obs;
      if (rst_n && (bus.game_start || bus.no_money)) begin
         obs = {bus.game_start, bus.no_money, bus.level, bus.ticket, bus.screen_sel, bus.deduct_req};
         if (exp_q.size() == 0) chk("sb_unexpected", obs, 0);
         else                   chk("sb_event", obs, exp_q.pop_front());
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [8:0] code);
      bus.key_code  = code;
      bus.key_valid = 1'b1;
      step(1);
      bus.key_valid = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_state"}, bus.state_dbg, ST_MENU);
      chk({tag, "_req"}, bus.deduct_req, 0);
      chk({tag, "_amt"}, bus.deduct_amt, 0);
      chk({tag, "_start"}, bus.game_start, 0);
      chk({tag, "_level"}, bus.level, 0);
      chk({tag, "_ticket"}, bus.ticket, 0);
      chk({tag, "_nomoney"}, bus.no_money, 0);
      chk({tag, "_screen"}, bus.screen_sel, 0);
   endtask

   initial begin
      bus.key_valid  = 1'b0;
      bus.key_code   = 9'h000;
      bus.money      = 7'd0;
      bus.deduct_ack = 1'b0;
      bus.game_done  = 1'b0;
      #1 rst_n = 1'b0;
      #11;
      chk_idle("rst");
      rst_n = 1'b1;
      step(1);
      chk_idle("post_rst");

      // insufficient funds
      bus.money = 7'd9;
      exp_q.push_back(evt(1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 1'b0));
      press(KEY_2);
      chk("t1_nm_pulse", bus.no_money, 1);
      step(1);
      chk_idle("t1_after");

      // unknown code and stray space in menu
      bus.money = 7'd50;
      press(9'h055);
      press(KEY_SPACE);
      chk_idle("ign_keys");

`ifdef GS_HELP_EN
      press(KEY_HELP);
      chk("help_state", bus.state_dbg, ST_HELP);
      chk("help_level", bus.level, 4);
      chk("help_screen", bus.screen_sel, 2);
      press(KEY_2);
      chk("help_k2_level", bus.level, 4);
      chk("help_k2_req", bus.deduct_req, 0);
      press(KEY_SPACE);
      chk_idle("help_exit");
`else
      press(KEY_HELP);
      chk_idle("help_off");
`endif

      bus.game_done = 1'b1;
      step(1);
      bus.game_done = 1'b0;
      chk_idle("gd_menu");

      // exact fee, ack after 5 cycles, full result dwell
      bus.money = 7'd10;
      exp_q.push_back(evt(1'b1, 1'b0, 3'd3, 1'b1, 2'd1, 1'b0));
      press(KEY_3);
      bus.money = 7'd0;
      for (int i = 1; i <= 5; i++) begin
         chk("t2_req", bus.deduct_req, 1);
         chk("t2_amt", bus.deduct_amt, FEE);
         chk("t2_nostart", bus.game_start, 0);
         if (i == 5) bus.deduct_ack = 1'b1;
         step(1);
         bus.deduct_ack = 1'b0;
      end
      chk("t2_start", bus.game_start, 1);
      chk("t2_level", bus.level, 3);
      chk("t2_ticket", bus.ticket, 1);
      chk("t2_screen", bus.screen_sel, 1);
      chk("t2_req_low", bus.deduct_req, 0);
      chk("t2_amt_low", bus.deduct_amt, 0);
      chk("t2_state", bus.state_dbg, ST_PLAY);
      step(1);
      chk("t2_start_drop", bus.game_start, 0);
      bus.deduct_ack = 1'b1;
      press(KEY_1);
      bus.deduct_ack = 1'b0;
      chk("t2_play_hold_lvl", bus.level, 3);
      chk("t2_play_hold_st", bus.state_dbg, ST_PLAY);
      bus.game_done = 1'b1;
      step(1);
      bus.game_done = 1'b0;
      for (int i = 1; i <= RES_CYC; i++) begin
         chk("t2_res_screen", bus.screen_sel, 3);
         chk("t2_res_level", bus.level, 3);
         chk("t2_res_ticket", bus.ticket, 1);
         step(1);
      end
      chk_idle("t2_res_end");

      // ack timeout, with a key during the charge
      bus.money = 7'd50;
      exp_q.push_back(evt(1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 1'b0));
      press(KEY_1);
      for (int i = 1; i <= ACK_TO; i++) begin
         chk("t3_req", bus.deduct_req, 1);
         if (i == 3) begin
            bus.key_valid = 1'b1;
            bus.key_code  = KEY_2;
         end
         step(1);
         bus.key_valid = 1'b0;
      end
      chk("t3_req_low", bus.deduct_req, 0);
      chk("t3_nm", bus.no_money, 1);
      chk("t3_level", bus.level, 0);
      chk("t3_state", bus.state_dbg, ST_MENU);
      step(1);
      chk("t3_nm_drop", bus.no_money, 0);

      // ack on the timeout cycle wins; space ends result early
      bus.money = 7'd10;
      exp_q.push_back(evt(1'b1, 1'b0, 3'd2, 1'b1, 2'd1, 1'b0));
      press(KEY_2);
      for (int i = 1; i <= ACK_TO; i++) begin
         chk("t4_req", bus.deduct_req, 1);
         if (i == ACK_TO) bus.deduct_ack = 1'b1;
         step(1);
         bus.deduct_ack = 1'b0;
      end
      chk("t4_start", bus.game_start, 1);
      chk("t4_level", bus.level, 2);
      chk("t4_nm", bus.no_money, 0);
      chk("t4_state", bus.state_dbg, ST_PLAY);
      bus.game_done = 1'b1;
      step(1);
      bus.game_done = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         chk("t4_res_screen", bus.screen_sel, 3);
         chk("t4_res_level", bus.level, 2);
         if (i == 3) begin
            bus.key_valid = 1'b1;
            bus.key_code  = KEY_SPACE;
         end
         step(1);
         bus.key_valid = 1'b0;
      end
      chk_idle("t4_space_exit");

      // reset during a charge
      bus.money = 7'd20;
      press(KEY_1);
      step(2);
      chk("t5_req_pre", bus.deduct_req, 1);
      rst_n = 1'b0;
      #1;
      chk_idle("rst_charge");
      step(2);
      rst_n = 1'b1;
      step(1);
      chk_idle("rst_charge_rel");
      bus.deduct_ack = 1'b1;
      step(1);
      bus.deduct_ack = 1'b0;
      chk_idle("ack_menu");

      // reset during play
      exp_q.push_back(evt(1'b1, 1'b0, 3'd1, 1'b1, 2'd1, 1'b0));
      press(KEY_1);
      chk("t5_req", bus.deduct_req, 1);
      bus.deduct_ack = 1'b1;
      step(1);
      bus.deduct_ack = 1'b0;
      chk("t5_level", bus.level, 1);
      step(1);
      rst_n = 1'b0;
      #1;
      chk_idle("rst_play");
      step(1);
      rst_n = 1'b1;
      step(1);

      // clean charge after reset
      exp_q.push_back(evt(1'b1, 1'b0, 3'd1, 1'b1, 2'd1, 1'b0));
      press(KEY_1);
      chk("t6_req", bus.deduct_req, 1);
      chk("t6_amt", bus.deduct_amt, FEE);
      chk("t6_state", bus.state_dbg, ST_CHARGE);
      bus.deduct_ack = 1'b1;
      step(1);
      bus.deduct_ack = 1'b0;
      chk("t6_start", bus.game_start, 1);
      chk("t6_ticket", bus.ticket, 1);
      step(3);

      chk("sb_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/game_session_ctrl.md
# game_session_ctrl

Session sequencer for the arcade front end. It takes decoded keypad events on the start screen, checks and collects the entry fee from the credit keeper through a request/acknowledge handshake, and launches the game core at the chosen level. It holds the session until the core reports completion, then shows a result screen before returning to the menu. It also drives `screen_sel`, which selects which image source feeds the VGA pixel mux.

## Interface
- `FEE`, 10: credits charged per session; compared against `money`.
- `ACK_TIMEOUT`, 1023: cycles to wait for `deduct_ack` before aborting a charge.
- `RESULT_CYCLES`, 100_000_000: result-screen dwell time in cycles; must be ≥1.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `key_valid`, in, 1: one-cycle pulse; a new key is held in `key_code`.
- `key_code`, in, 9: scan code. 0x16 = '1', 0x1E = '2', 0x26 = '3', 0x4A = '?', 0x29 = space; all other codes are ignored.
- `money`, in, 7: current credit balance, unsigned.
- `deduct_req`, out, 1: charge request to the credit keeper; level-held.
- `deduct_amt`, out, 7: amount to charge; equals `FEE` while `deduct_req` is high, 0 otherwise.
- `deduct_ack`, in, 1: one-cycle pulse; the charge has been applied.
- `game_start`, out, 1: one-cycle pulse to the game core.
- `level`, out, 3: 0 = none, 1–3 = game level, 4 = help.
- `ticket`, out, 1: a paid session is active.
- `game_done`, in, 1: one-cycle pulse from the game core.
- `no_money`, out, 1: one-cycle pulse; the key was refused because funds are insufficient or the charge timed out.
- `screen_sel`, out, 2: 0 = menu, 1 = game, 2 = help, 3 = result.

## Operation
- FSM states: MENU, CHARGE, PLAY, HELP, RESULT. Reset state is MENU.
- Reset values: `level`=0, `ticket`=0, `deduct_req`=0, `deduct_amt`=0, `game_start`=0, `no_money`=0, `screen_sel`=0. All counters are cleared.
- MENU:
  - `key_valid` with '1', '2' or '3' and `money` ≥ `FEE` (compared in the same cycle): latch the level into a pending register, go to CHARGE.
  - Same keys with `money` < `FEE`: pulse `no_money`, stay in MENU, `level` stays 0.
  - '?': go to HELP with `level`=4. This is free.
  - Any other code: ignored.
- CHARGE:
  - `deduct_req`=1 and `deduct_amt`=`FEE` for the whole state. Incoming keys are ignored.
  - On `deduct_ack`: drop `deduct_req`, set `level` to the pending value, set `ticket`=1, pulse `game_start`, go to PLAY.
  - If the wait counter reaches `ACK_TIMEOUT` with no ack: drop `deduct_req`, pulse `no_money`, return to MENU with `level`=0.
- PLAY:
  - `screen_sel`=1. Keys are ignored (the game core consumes them).
  - On `game_done`: go to RESULT and load the dwell counter with `RESULT_CYCLES`−1.
- RESULT:
  - `screen_sel`=3. `level` and `ticket` are held.
  - Exit when the counter reaches 0, or on `key_valid` with space, whichever comes first.
  - On exit: `level`=0, `ticket`=0, go to MENU.
- HELP:
  - `screen_sel`=2.
  - `key_valid` with space or '?': return to MENU with `level`=0.
- Simultaneous events:
  - `deduct_ack` and timeout expiry in the same cycle: the ack wins.
  - A `deduct_ack` outside CHARGE is ignored.
  - A `game_done` outside PLAY is ignored.
  - Changes in `money` are only sampled at the MENU key cycle.

## Timing
- Every output is registered.
- Key accept in MENU → CHARGE entry, with `deduct_req` high on the next edge.
- `deduct_ack` at edge N:
  - `game_start` is high for exactly the cycle after N.
  - `level`, `ticket` and `screen_sel`=1 are valid from that same cycle.
  - `deduct_req` is low from that same cycle.
- `game_done` at edge N → `screen_sel`=3 in the cycle after N. RESULT lasts exactly `RESULT_CYCLES` cycles unless space ends it early.
- `no_money` is always one cycle wide and is registered one cycle after its cause.
- An `rst_n` assertion in any state clears the FSM and outputs asynchronously. A pending charge is abandoned with no ack expected.

## Configuration
- `GS_HELP_EN`:
  - Defined: the HELP state and the '?' handling exist as described.
  - Undefined: HELP is not built, '?' is ignored in MENU, and `level` never takes the value 4.

## Test plan
- `money`=9, key '2' → `no_money` pulses once; state stays MENU; `deduct_req` stays 0; `level`=0.
- `money`=10, key '3', ack after 5 cycles:
  - `deduct_req` high for 5 cycles with `deduct_amt`=10.
  - Then one `game_start` pulse, with `level`=3, `ticket`=1, `screen_sel`=1.
- `money`=50, key '1', no ack, `ACK_TIMEOUT`=16 → `deduct_req` drops after 16 cycles; `no_money` pulses; state returns to MENU.
- PLAY at level 2, `game_done`, `RESULT_CYCLES`=8:
  - `screen_sel`=3 for 8 cycles, then 0.
  - `level` and `ticket` clear to 0.
  - A repeat with space on cycle 3 exits at cycle 3.
- '?' in MENU → `level`=4, `screen_sel`=2; key '2' is ignored; space returns to MENU. Without `GS_HELP_EN`, '?' causes no change.
- `rst_n` pulled low during CHARGE and during PLAY → all outputs return to their reset values immediately; after release, '1' with `money`=20 starts a clean charge.
